// File: rtl/ps2_scancode_decoder_if.sv
// Handshake bundle between the PS/2 decoder, the host RX FIFO read port and
// the CPU event holding register.
interface ps2_scancode_decoder_if;
  logic [7:0] kbd_rdata_i;
  logic       kbd_rvalid_i;
  logic       kbd_rdeq_o;
  logic [7:0] evt_key_o;
  logic       evt_brk_o;
  logic       evt_valid_o;
  logic       evt_ack_i;

  modport master (
    input  kbd_rdata_i, kbd_rvalid_i, evt_ack_i,
    output kbd_rdeq_o, evt_key_o, evt_brk_o, evt_valid_o
  );

  modport slave (
    output kbd_rdata_i, kbd_rvalid_i, evt_ack_i,
    input  kbd_rdeq_o, evt_key_o, evt_brk_o, evt_valid_o
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code parser: drains the keyboard RX FIFO, folds E0/F0/E1
// prefixes into single key events and tracks the modifier bitmap.
module ps2_scancode_decoder (
  input  logic                          clk6x,
  input  logic                          resetn,
  ps2_scancode_decoder_if.master        bus,
  input  logic                          enable_i,
  input  logic                          flush_i,
  output logic [7:0]                    mods_o,
  output logic                          ovr_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0,
    ST_PAUSE
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] skip_cnt, skip_cnt_nxt;
  logic       cool;
  logic       take;
  logic       emit;
  logic [7:0] emit_key;
  logic       emit_brk;
  logic       ovr_set;
  logic [7:0] byte_in;
  logic [7:0] evt_key;
  logic       evt_brk;
  logic       evt_valid;
  logic [7:0] mods;
  logic       ovr;
  logic       ext_state;

  function automatic logic [7:0] mod_mask(input logic [7:0] key);
    case (key)
      8'h14:   return 8'h01;
      8'h12:   return 8'h02;
      8'h11:   return 8'h04;
      8'h9F:   return 8'h08;
      8'h94:   return 8'h10;
      8'h59:   return 8'h20;
      8'h91:   return 8'h40;
      8'hA7:   return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic is_key_byte(input logic [7:0] b);
    return ((b >= 8'h01) && (b <= 8'h7F)) || (b == 8'h83);
  endfunction

  assign byte_in   = bus.kbd_rdata_i;
  assign ext_state = (state == ST_E0) || (state == ST_E0F0);

  // A byte is taken only when the holding register is free or being freed now.
  assign take = bus.kbd_rvalid_i & enable_i & ~cool & ~flush_i &
                (~evt_valid | bus.evt_ack_i);

  always_ff @(posedge clk6x) begin
    if (!resetn || flush_i) begin
      state    <= ST_IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    skip_cnt_nxt = skip_cnt;
    emit         = 1'b0;
    emit_key     = 8'h00;
    emit_brk     = 1'b0;
    ovr_set      = 1'b0;
    if (take) begin
      if (state == ST_PAUSE) begin
        skip_cnt_nxt = skip_cnt - 3'd1;
        if (skip_cnt == 3'd1) begin
          emit      = 1'b1;
          emit_key  = 8'hFF;
          state_nxt = ST_IDLE;
        end
      end else if (is_key_byte(byte_in)) begin
        state_nxt = ST_IDLE;
        // E0 12 / E0 59 are the keyboard's fake shifts around extended keys.
        if (!(ext_state && ((byte_in == 8'h12) || (byte_in == 8'h59)))) begin
          emit     = 1'b1;
          emit_key = {ext_state, (byte_in == 8'h83) ? 7'h02 : byte_in[6:0]};
          emit_brk = (state == ST_F0) || (state == ST_E0F0);
        end
      end else if ((byte_in == 8'hE0) && ((state == ST_IDLE) || (state == ST_E0))) begin
        state_nxt = ST_E0;
      end else if ((byte_in == 8'hF0) && (state == ST_IDLE)) begin
        state_nxt = ST_F0;
      end else if ((byte_in == 8'hF0) && (state == ST_E0)) begin
        state_nxt = ST_E0F0;
      end else if ((byte_in == 8'hE1) && (state == ST_IDLE)) begin
        state_nxt    = ST_PAUSE;
        skip_cnt_nxt = 3'd7;
      end else begin
        state_nxt = ST_IDLE;
        ovr_set   = (byte_in == 8'h00) || (byte_in == 8'hFF);
      end
    end
  end

  always_ff @(posedge clk6x) begin
    if (!resetn || flush_i) begin
      evt_valid <= 1'b0;
      mods      <= 8'h00;
      ovr       <= 1'b0;
      cool      <= 1'b0;
    end else begin
      cool <= take;
      if (emit) begin
        evt_valid <= 1'b1;
        mods      <= emit_brk ? (mods & ~mod_mask(emit_key)) : (mods | mod_mask(emit_key));
      end else if (bus.evt_ack_i) begin
        evt_valid <= 1'b0;
      end
      if (ovr_set) begin
        ovr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      evt_key <= 8'h00;
      evt_brk <= 1'b0;
    end else if (emit) begin
      evt_key <= emit_key;
      evt_brk <= emit_brk;
    end
  end

  assign bus.kbd_rdeq_o  = take;
  assign bus.evt_key_o   = evt_key;
  assign bus.evt_brk_o   = evt_brk;
  assign bus.evt_valid_o = evt_valid;
  assign mods_o          = mods;
  assign ovr_o           = ovr;

endmodule
